// File: rtl/systolic_seq.sv
// systolic_seq: tile-loop sequencer for one GEMM job on a systolic array
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start, cfg_cnt_a/b, cfg_is_int  job launch and configuration, latched on accepted start
//   c/a/b_req, c/a/b_ack            SRAM load handshakes (req held until ack is sampled)
//   sys_go/sys_done                 systolic pass launch pulse / completion pulse
//   acc_go/acc_done                 accumulation launch pulse / completion pulse
//   a_idx, b_idx, state             current tile indices and FSM state
//   busy, done, cfg_err             status: not idle, job finished, rejected start
module systolic_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_cnt_a,
  input  logic [CNT_W-1:0] cfg_cnt_b,
  input  logic             cfg_is_int,
  output logic             c_req,
  input  logic             c_ack,
  output logic             a_req,
  input  logic             a_ack,
  output logic             b_req,
  input  logic             b_ack,
  output logic             sys_go,
  input  logic             sys_done,
  output logic             acc_go,
  input  logic             acc_done,
  output logic [CNT_W-1:0] a_idx,
  output logic [CNT_W-1:0] b_idx,
  output logic [2:0]       state,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);
  typedef enum logic [2:0] {
    IDLE, READ_C, SYSTOLIC, ACCUMULATE, WAIT_A, WAIT_B, WAIT_C, FINISH
  } st_t;
  st_t st, st_n;
  logic [CNT_W-1:0] cnt_a, cnt_b, cnt_a_n, cnt_b_n, a_n, b_n;
  logic is_int, is_int_n, pf, pf_n, entry, entry_n, err_n, adv, a_last, b_last;
  // comparing against count-1 keeps the loop tests inside CNT_W bits, so max counts never wrap
  assign a_last = a_idx == cnt_a - CNT_W'(1);
  assign b_last = b_idx == cnt_b - CNT_W'(1);
  assign state  = st;
  assign busy   = st != IDLE;
  assign done   = st == FINISH;
  assign c_req  = st == READ_C;
  assign a_req  = st == WAIT_C;
  assign b_req  = st == WAIT_A || st == WAIT_B || (st == SYSTOLIC && !b_last && !pf);
  // entry marks the first cycle after any transition, including SYSTOLIC re-entry
  assign sys_go = entry && st == SYSTOLIC;
  assign acc_go = entry && st == ACCUMULATE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      a_idx   <= '0;
      b_idx   <= '0;
      cnt_a   <= '0;
      cnt_b   <= '0;
      is_int  <= 1'b0;
      pf      <= 1'b0;
      entry   <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      st      <= st_n;
      a_idx   <= a_n;
      b_idx   <= b_n;
      cnt_a   <= cnt_a_n;
      cnt_b   <= cnt_b_n;
      is_int  <= is_int_n;
      pf      <= pf_n;
      entry   <= entry_n;
      cfg_err <= err_n;
    end
  end
  always_comb begin
    st_n     = st;
    a_n      = a_idx;
    b_n      = b_idx;
    cnt_a_n  = cnt_a;
    cnt_b_n  = cnt_b;
    is_int_n = is_int;
    pf_n     = pf;
    err_n    = 1'b0;
    adv      = 1'b0;
    case (st)
      IDLE: if (start) begin
        if (cfg_cnt_a != '0 && cfg_cnt_b != '0) begin
          st_n     = READ_C;
          a_n      = '0;
          b_n      = '0;
          pf_n     = 1'b0;
          cnt_a_n  = cfg_cnt_a;
          cnt_b_n  = cfg_cnt_b;
          is_int_n = cfg_is_int;
        end else err_n = 1'b1;
      end
      READ_C:     st_n = c_ack ? WAIT_C : st;
      WAIT_C:     st_n = a_ack ? WAIT_A : st;
      WAIT_A:     st_n = b_ack ? SYSTOLIC : st;
      WAIT_B:     st_n = b_ack ? SYSTOLIC : st;
      SYSTOLIC: begin
        pf_n = pf || (b_req && b_ack);
        st_n = sys_done && is_int ? ACCUMULATE : st;
        adv  = sys_done && !is_int;
      end
      ACCUMULATE: adv = acc_done;
      FINISH:     st_n = IDLE;
    endcase
    // tile advance: a prefetched B tile (including one acked this very cycle) skips WAIT_B
    if (adv) begin
      if (!b_last) begin
        b_n  = b_idx + CNT_W'(1);
        st_n = pf_n ? SYSTOLIC : WAIT_B;
        pf_n = 1'b0;
      end else if (!a_last) begin
        a_n  = a_idx + CNT_W'(1);
        b_n  = '0;
        pf_n = 1'b0;
        st_n = READ_C;
      end else st_n = FINISH;
    end
    entry_n = st_n != st || adv;
  end
endmodule

// File: doc/systolic_seq.md
SYSTOLIC_SEQ -- requirements
Module: systolic_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 8, giving the width of the A/B tile-loop counters.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1: pulse that launches one GEMM job; sampled only in IDLE.
REQ-005 SHALL have port cfg_cnt_a, input, CNT_W: number of A tiles per job (counter_A).
REQ-006 SHALL have port cfg_cnt_b, input, CNT_W: number of B tiles per A tile (counter_B).
REQ-007 SHALL have port cfg_is_int, input, 1: 1 = INT8/INT4 job, so ACCUMULATE runs after each SYSTOLIC pass.
REQ-008 SHALL have ports c_req/c_ack, a_req/a_ack and b_req/b_ack: req output 1, ack input 1, the load handshakes for the C, A and B SRAMs.
REQ-009 SHALL have port sys_go, output, 1: one-cycle pulse that starts a systolic pass.
REQ-010 SHALL have port sys_done, input, 1: pulse that ends a systolic pass.
REQ-011 SHALL have port acc_go, output, 1: one-cycle pulse that starts accumulation.
REQ-012 SHALL have port acc_done, input, 1: pulse that ends accumulation.
REQ-013 SHALL have ports a_idx and b_idx, output, CNT_W each: current A and B tile indices.
REQ-014 SHALL have port state, output, 3: current state, encoded IDLE=0, READ_C=1, SYSTOLIC=2, ACCUMULATE=3, WAIT_A=4, WAIT_B=5, WAIT_C=6, FINISH=7.
REQ-015 SHALL have ports busy, done and cfg_err, output, 1 each.

Function
REQ-016 SHALL latch cfg_cnt_a, cfg_cnt_b and cfg_is_int on an accepted start; later changes to these inputs SHALL have no effect on the running job.
REQ-017 On start in IDLE with both counts nonzero, SHALL go to READ_C, clear a_idx and b_idx, and clear the prefetch flag.
REQ-018 On start in IDLE with either count zero, SHALL stay in IDLE and pulse cfg_err for one cycle.
REQ-019 SHALL ignore start in every state other than IDLE.
REQ-020 READ_C: SHALL assert c_req; the cycle after c_ack, SHALL go to WAIT_C.
REQ-021 WAIT_C: SHALL assert a_req; the cycle after a_ack, SHALL go to WAIT_A.
REQ-022 WAIT_A: SHALL assert b_req; the cycle after b_ack, SHALL go to SYSTOLIC.
REQ-023 SHALL hold each req high, level-sensitive, until its ack is sampled, and SHALL deassert it in the cycle after the ack.
REQ-024 SHALL assert sys_go for exactly the first cycle of each SYSTOLIC entry.
REQ-025 In SYSTOLIC, when b_idx+1 < cnt_b and the prefetch flag is clear, SHALL assert b_req (double-buffer prefetch); b_ack SHALL set the prefetch flag and drop b_req.
REQ-026 On sys_done: if is_int, SHALL go to ACCUMULATE and pulse acc_go in its first cycle; otherwise SHALL perform the tile-advance step (REQ-029).
REQ-027 If sys_done and b_ack arrive in the same cycle, SHALL honour both: set the flag and take the transition.
REQ-028 ACCUMULATE: on acc_done, SHALL perform the tile-advance step.
REQ-029 Tile-advance step, inner B loop: if b_idx+1 < cnt_b, SHALL increment b_idx, then:
  - prefetch flag set: clear it and go to SYSTOLIC;
  - prefetch flag clear: go to WAIT_B, assert b_req, and on b_ack go to SYSTOLIC.
REQ-030 Tile-advance step, outer A loop:
  - if b_idx+1 = cnt_b and a_idx+1 < cnt_a: SHALL increment a_idx, clear b_idx and go to READ_C;
  - if b_idx+1 = cnt_b and a_idx+1 = cnt_a: SHALL go to FINISH.
REQ-031 FINISH: SHALL pulse done for one cycle, then go to IDLE.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 Counters SHALL never wrap; cnt_a = cnt_b = 2^CNT_W-1 SHALL run to completion.
REQ-034 Any ack, sys_done or acc_done arriving outside its waiting state SHALL be ignored.

Reset
REQ-035 While rst_n is low, state SHALL be IDLE and every output SHALL be 0, including req, go, done, cfg_err, the indices and the prefetch flag.
REQ-036 Reset asserted mid-job SHALL abort the job immediately with no done pulse.
REQ-037 After reset deasserts, SHALL accept start on the next clock edge.

Verification
REQ-038 FP job, cnt_a=1, cnt_b=1, acks returned one cycle after each req -> visits READ_C, WAIT_C, WAIT_A, SYSTOLIC, FINISH; exactly one sys_go, zero acc_go, one done.
REQ-039 INT job, cnt_a=2, cnt_b=3 -> 6 sys_go and 6 acc_go; 2 c_req handshakes; (a_idx,b_idx) sequence (0,0)(0,1)(0,2)(1,0)(1,1)(1,2).
REQ-040 FP job, cnt_b=2, b_ack returned during SYSTOLIC -> after sys_done goes directly to SYSTOLIC with no WAIT_B; if b_ack is instead withheld until after sys_done, the state passes through WAIT_B.
REQ-041 b_ack and sys_done in the same cycle -> no second b_req is issued, next state is SYSTOLIC.
REQ-042 start with cfg_cnt_b=0 -> one-cycle cfg_err, state stays 0; start while busy -> no effect on the indices or the state sequence.
REQ-043 rst_n pulled low in ACCUMULATE while holding c_req or b_req -> all outputs 0 asynchronously, no done; the next start runs a clean job.
